// File: rtl/uart_mem_responder.sv
// UART memory-protocol target: turns rx command frames into one 32-bit memory
// access and streams back the read word or a 0xC8 write acknowledge.
module uart_mem_responder #(
  parameter logic [31:0] TimeoutCycles = 32'd65536
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  rx_tdata_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  output logic [7:0]  tx_tdata_o,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        mem_valid_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        err_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RECV_ADDR = 3'd1;
  localparam logic [2:0] RECV_DATA = 3'd2;
  localparam logic [2:0] MEM_REQ   = 3'd3;
  localparam logic [2:0] SEND_DATA = 3'd4;
  localparam logic [2:0] SEND_ACK  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] tmo_q, tmo_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        err_q, err_d;

  logic        rx_ready;
  logic        rx_hs;
  logic        tx_hs;
  logic [1:0]  cnt_next;

  assign rx_ready = !reset_i &&
                    (state_q == IDLE || state_q == RECV_ADDR || state_q == RECV_DATA);
  assign rx_hs    = rx_tvalid_i && rx_ready;
  assign tx_hs    = tx_valid_q && tx_tready_i;
  assign cnt_next = cnt_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_hs) begin
          if (rx_tdata_i == 8'h77) begin
            wstrb_d = 4'h0;
            state_d = RECV_ADDR;
          end else if (rx_tdata_i[7:4] == 4'h2 && rx_tdata_i[3:0] != 4'h0) begin
            wstrb_d = rx_tdata_i[3:0];
            state_d = RECV_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RECV_ADDR, RECV_DATA: begin
        if (rx_hs) begin
          if (state_q == RECV_ADDR) addr_d[{cnt_q, 3'b000} +: 8] = rx_tdata_i;
          else                      wdata_d[{cnt_q, 3'b000} +: 8] = rx_tdata_i;
          cnt_d = cnt_next;
          if (cnt_q == 2'd3) begin
            if (state_q == RECV_ADDR && wstrb_q != 4'h0) begin
              state_d = RECV_DATA;
            end else begin
              state_d     = MEM_REQ;
              mem_valid_d = 1'b1;
            end
          end
        end else if (TimeoutCycles != 32'd0 && tmo_q + 32'd1 == TimeoutCycles) begin
          // Stalled sender: drop the partial frame and resync on the next command byte.
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      MEM_REQ: begin
        cnt_d = '0;
        if (mem_ready_i) begin
          mem_valid_d = 1'b0;
          tx_valid_d  = 1'b1;
          if (wstrb_q == 4'h0) begin
            rdata_d   = mem_rdata_i;
            tx_data_d = mem_rdata_i[7:0];
            state_d   = SEND_DATA;
          end else begin
            tx_data_d = 8'hC8;
            state_d   = SEND_ACK;
          end
        end
      end

      SEND_DATA: begin
        if (tx_hs) begin
          cnt_d = cnt_next;
          if (cnt_q == 2'd3) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
          end else begin
            tx_data_d = rdata_q[{cnt_next, 3'b000} +: 8];
          end
        end
      end

      SEND_ACK: begin
        cnt_d = '0;
        if (tx_hs) begin
          tx_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      wstrb_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      err_q       <= err_d;
    end
  end

  assign rx_tready_o = rx_ready;
  assign tx_tdata_o  = tx_data_q;
  assign tx_tvalid_o = tx_valid_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_wstrb_o = wstrb_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;

endmodule

// File: doc/uart_mem_responder.md
# uart_mem_responder

Target-side responder for the UART memory protocol. It consumes command frames from a UART receive byte stream, performs one 32-bit access on a local memory port, and returns either the read word or a write acknowledge on the UART transmit byte stream. It sits between the `uart` core's AXI-stream byte ports and a word-addressed RAM or bus. This lets hardware or a test harness serve the CPU-side UART RAM bridge without the host program.

## Interface
- `TimeoutCycles`, default 32'd65536: idle cycles allowed between bytes of one frame before the frame is aborted; 0 disables the timeout.
- `clk_i` in 1: clock; all logic on posedge.
- `reset_i` in 1: asynchronous, active-high reset.
- `rx_tdata_i` in 8: received byte from the UART.
- `rx_tvalid_i` in 1: received byte valid.
- `rx_tready_o` out 1: responder accepts a byte.
- `tx_tdata_o` out 8: byte to transmit.
- `tx_tvalid_o` out 1: transmit byte valid.
- `tx_tready_i` in 1: UART accepts the byte.
- `mem_valid_o` out 1: memory request.
- `mem_wstrb_o` out 4: byte strobes; 0 means read.
- `mem_addr_o` out 32: byte address, passed through unmodified.
- `mem_wdata_o` out 32: write data.
- `mem_rdata_i` in 32: read data; sampled on the `mem_ready_i` cycle.
- `mem_ready_i` in 1: request complete.
- `err_o` out 1: one-cycle pulse on an invalid command or a timeout.

## Operation
- Frame formats. All multi-byte fields are sent LSB first.
  - Read: `0x77`, then 4 address bytes. The reply is 4 data bytes.
  - Write: `{4'h2, wstrb}` with wstrb ≠ 0, then 4 address bytes, then 4 data bytes. The reply is `0xC8`.
- Any other command byte, including `0x20`: the byte is consumed, `err_o` pulses, and the FSM stays in Idle.
- FSM states and transitions:
  - Idle: on a command handshake, latch the strobe (0 for a read) and go to RecvAddr.
  - RecvAddr: each handshake shifts a byte into `addr_q[8*cnt +: 8]`. On the 4th byte, go to RecvData for a write or MemReq for a read.
  - RecvData: same scheme into `wdata_q`. On the 4th byte, go to MemReq.
  - MemReq: go to SendData (read) or SendAck (write) on `mem_ready_i`. For a read, latch `mem_rdata_i` into `rdata_q`.
  - SendData: present `rdata_q[8*cnt +: 8]`. After the 4th tx handshake, go to Idle.
  - SendAck: present `0xC8`. After the handshake, go to Idle.
- Byte counter: 2 bits, increments on each handshake in RecvAddr, RecvData and SendData. It wraps to 0 on the 4th byte and is 0 in every other state.
- Timeout counter:
  - Cleared on every rx handshake and in every state other than RecvAddr/RecvData.
  - Increments each cycle in RecvAddr/RecvData with no handshake.
  - Reaching `TimeoutCycles` (when nonzero): return to Idle, reset the counter, pulse `err_o`. Partial registers are discarded.
- `rx_tready_o` = 1 only in Idle, RecvAddr and RecvData, and 0 while `reset_i` is high. Incoming bytes are back-pressured during MemReq and the send states.
- Exactly one memory request per valid frame. No request is issued for an aborted or invalid frame.

## Timing
- Reset values: state Idle; counters 0; `tx_tvalid_o`, `tx_tdata_o`, `mem_valid_o`, `mem_wstrb_o`, `mem_addr_o`, `mem_wdata_o` and `err_o` all 0. Async reset mid-frame clears everything in the same instant.
- `mem_valid_o` is registered:
  - It rises the cycle after the final rx byte handshake.
  - `mem_addr_o`, `mem_wstrb_o` and `mem_wdata_o` are stable while it is high.
  - It falls the cycle after `mem_ready_i`.
  - `mem_ready_i` may be high in the first valid cycle, so a 1-cycle access is legal.
- `tx_tvalid_o` rises the cycle after `mem_ready_i`. `tx_tdata_o` and `tx_tvalid_o` are held until `tx_tready_i`, and the next byte follows in the next cycle.
- Minimum latency:
  - Read: 1 cycle from the last address byte to `mem_valid_o`.
  - Write: 1 cycle from `mem_ready_i` to `0xC8` valid.
- `err_o` is registered and asserts the cycle after the offending handshake or the timeout expiry.
- A new command is accepted the cycle after the final tx handshake.

## Test plan
- Read: rx `77 10 00 00 00`; memory returns `0xDEADBEEF` 2 cycles after request.
  - Expect one request with addr `0x00000010`, wstrb `0000`.
  - Expect tx `EF BE AD DE`, then Idle.
- Full write: rx `2F 04 00 00 00 78 56 34 12`, `mem_ready_i` in the first cycle.
  - Expect addr 4, wstrb `1111`, wdata `0x12345678`.
  - Expect tx `C8`.
- Partial write: command `0x23` → wstrb `0011`. Command `0x28` → wstrb `1000`. Each acked with `C8`.
- Invalid commands: rx `55`, then `20`.
  - Expect two `err_o` pulses and no `mem_valid_o`.
  - A following read frame completes correctly.
- Timeout (`TimeoutCycles`=100): rx `77 10`, then silence.
  - Expect `err_o` pulse at cycle 100 and return to Idle.
  - A next frame `77 00 00 00 00` reads address 0.
- Tx backpressure and reset:
  - Hold `tx_tready_i` low 50 cycles during SendData: byte 1 stays stable, `rx_tready_o`=0.
  - Assert `reset_i` mid-SendData: `tx_tvalid_o`=0 immediately, state Idle.
